// File: rtl/cdu_drive_sched.sv
// ---------------------------------------------------------------------------
// cdu_drive_sched
//   Shares the single CDU drive pulse slot round-robin between the five
//   IMU/optics drive channels (0=X, 1=Y, 2=Z gimbal, 3=trunnion, 4=shaft).
//   Software loads a signed ones-complement pulse count per channel. The
//   block emits one +/- pulse per slot tick to the next active channel and
//   flags each channel whose count drains to zero.
//
// Ports
//   clk    in   system clock, rising edge
//   rst_   in   synchronous active-low reset
//   ENA    in   [4:0]  per-channel drive enable
//   WR     in   one-clk write strobe
//   WSEL   in   [2:0]  channel for WR (5..7 ignored)
//   WDATA  in   [14:0] ones-complement count, bit 14 = sign
//   RSEL   in   [2:0]  readback channel (5..7 read as 0)
//   RDATA  out  [14:0] remaining count of RSEL channel (combinational)
//   DRV    out  [4:0]  one-clk drive pulse, at most one bit set
//   DRVM   out  sign of the current pulse (1 = minus), 0 when DRV == 0
//   BUSY   out  [4:0]  channel has a nonzero remaining count
//   DONE   out  [4:0]  one-clk pulse when a count drains to zero
// ---------------------------------------------------------------------------
module cdu_drive_sched #(
    parameter int unsigned TICKDIV = 8
) (
    input  logic        clk,
    input  logic        rst_,
    input  logic [4:0]  ENA,
    input  logic        WR,
    input  logic [2:0]  WSEL,
    input  logic [14:0] WDATA,
    input  logic [2:0]  RSEL,
    output logic [14:0] RDATA,
    output logic [4:0]  DRV,
    output logic        DRVM,
    output logic [4:0]  BUSY,
    output logic [4:0]  DONE
);

    localparam logic [7:0] DIV_LAST = 8'(TICKDIV - 1);

    logic [7:0]  div_q, div_d;
    logic [13:0] mag_q [5];
    logic [13:0] mag_d [5];
    logic [4:0]  neg_q, neg_d;
    logic [2:0]  last_q, last_d;
    logic [4:0]  drv_q, drv_d;
    logic [4:0]  done_q, done_d;
    logic        drvm_q, drvm_d;

    logic        tick_s;
    logic [4:0]  cand_s;
    logic        hit_s;
    logic [2:0]  grant_s;

    // Channel index arithmetic modulo 5 for sums in 0..9.
    function automatic logic [2:0] wrap5(input logic [3:0] v);
        logic [3:0] r;
        r = (v >= 4'd5) ? (v - 4'd5) : v;
        return r[2:0];
    endfunction

    // Ones-complement word to magnitude: negative words are inverted.
    function automatic logic [13:0] oc_mag(input logic [14:0] w);
        return w[14] ? ~w[13:0] : w[13:0];
    endfunction

    assign tick_s = (div_q == DIV_LAST);

    // Busy flags and arbitration candidates.
    always_comb begin
        BUSY   = 5'd0;
        cand_s = 5'd0;
        for (int i = 0; i < 5; i++) begin
            BUSY[i]   = (mag_q[i] != 14'd0);
            cand_s[i] = BUSY[i] & ENA[i];
        end
    end

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        logic [2:0] idx_v;
        hit_s   = 1'b0;
        grant_s = 3'd0;
        idx_v   = 3'd0;
        for (int k = 1; k <= 5; k++) begin
            idx_v = wrap5({1'b0, last_q} + 4'(k));
            if (!hit_s && cand_s[idx_v]) begin
                hit_s   = 1'b1;
                grant_s = idx_v;
            end else begin
                hit_s   = hit_s;
            end
        end
    end

    // Next-state for divider, per-channel counts and the pulse outputs.
    // On a write/grant collision the pulse uses the pre-write count while
    // the channel takes the written value without a decrement.
    always_comb begin
        div_d  = tick_s ? 8'd0 : (div_q + 8'd1);
        neg_d  = neg_q;
        last_d = last_q;
        drv_d  = 5'd0;
        done_d = 5'd0;
        drvm_d = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mag_d[i] = mag_q[i];
            if (!ENA[i]) begin
                mag_d[i] = 14'd0;
            end else if (WR && (WSEL == 3'(i))) begin
                mag_d[i] = oc_mag(WDATA);
                neg_d[i] = WDATA[14];
            end else if (tick_s && hit_s && (grant_s == 3'(i))) begin
                mag_d[i] = mag_q[i] - 14'd1;
            end else begin
                mag_d[i] = mag_q[i];
            end
            if (tick_s && hit_s && (grant_s == 3'(i))) begin
                drv_d[i]  = 1'b1;
                drvm_d    = neg_q[i];
                done_d[i] = (mag_q[i] == 14'd1);
                last_d    = 3'(i);
            end else begin
                drv_d[i]  = 1'b0;
            end
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_) begin
            div_q  <= 8'd0;
            neg_q  <= 5'd0;
            last_q <= 3'd4;
            drv_q  <= 5'd0;
            done_q <= 5'd0;
            drvm_q <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                mag_q[i] <= 14'd0;
            end
        end else begin
            div_q  <= div_d;
            neg_q  <= neg_d;
            last_q <= last_d;
            drv_q  <= drv_d;
            done_q <= done_d;
            drvm_q <= drvm_d;
            for (int i = 0; i < 5; i++) begin
                mag_q[i] <= mag_d[i];
            end
        end
    end

    // Readback mux; a zero magnitude always reads as +0.
    always_comb begin
        RDATA = 15'd0;
        for (int i = 0; i < 5; i++) begin
            if ((RSEL == 3'(i)) && (mag_q[i] != 14'd0)) begin
                RDATA = neg_q[i] ? {1'b1, ~mag_q[i]} : {1'b0, mag_q[i]};
            end else begin
                RDATA = RDATA;
            end
        end
    end

    assign DRV  = drv_q;
    assign DRVM = drvm_q;
    assign DONE = done_q;

endmodule

// File: tb/tb_cdu_drive_sched.sv
// ---------------------------------------------------------------------------
// tb_cdu_drive_sched
//   Directed bench for cdu_drive_sched with TICKDIV=8. After reset release
//   the bench counts clock edges in cyc; the divider then equals cyc % 8, so
//   pulses can only be seen right after edges where cyc is a multiple of 8.
// ---------------------------------------------------------------------------
module tb_cdu_drive_sched;

    logic        clk;
    logic        rst_;
    logic [4:0]  ENA;
    logic        WR;
    logic [2:0]  WSEL;
    logic [14:0] WDATA;
    logic [2:0]  RSEL;
    logic [14:0] RDATA;
    logic [4:0]  DRV;
    logic        DRVM;
    logic [4:0]  BUSY;
    logic [4:0]  DONE;

    int checks_q;
    int failures_q;
    int cyc;

    cdu_drive_sched #(.TICKDIV(8)) dut (
        .clk   (clk),
        .rst_  (rst_),
        .ENA   (ENA),
        .WR    (WR),
        .WSEL  (WSEL),
        .WDATA (WDATA),
        .RSEL  (RSEL),
        .RDATA (RDATA),
        .DRV   (DRV),
        .DRVM  (DRVM),
        .BUSY  (BUSY),
        .DONE  (DONE)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_q++;
        if (got !== exp) begin
            failures_q++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Advance to edge count target; non-slot cycles must be pulse-free.
    task automatic run_to(input int target);
        while (cyc < target) begin
            step();
            if ((cyc % 8) != 0) begin
                chk("gap_drv", {27'd0, DRV}, 32'd0);
                chk("gap_done", {27'd0, DONE}, 32'd0);
            end
        end
    endtask

    // Advance to the next slot edge and check the pulse outputs there.
    task automatic slot(input logic [4:0] e_drv, input logic e_drvm,
                        input logic [4:0] e_done, input logic [14:0] e_rd);
        run_to((cyc / 8 + 1) * 8);
        chk("slot_drv", {27'd0, DRV}, {27'd0, e_drv});
        chk("slot_drvm", {31'd0, DRVM}, {31'd0, e_drvm});
        chk("slot_done", {27'd0, DONE}, {27'd0, e_done});
        chk("slot_rdata", {17'd0, RDATA}, {17'd0, e_rd});
    endtask

    task automatic wr(input logic [2:0] sel, input logic [14:0] data);
        WR    = 1'b1;
        WSEL  = sel;
        WDATA = data;
        step();
        WR    = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_drv"}, {27'd0, DRV}, 32'd0);
        chk({tag, "_drvm"}, {31'd0, DRVM}, 32'd0);
        chk({tag, "_done"}, {27'd0, DONE}, 32'd0);
        chk({tag, "_busy"}, {27'd0, BUSY}, 32'd0);
        chk({tag, "_rdata"}, {17'd0, RDATA}, 32'd0);
    endtask

    initial begin
        checks_q   = 0;
        failures_q = 0;
        cyc        = 0;
        rst_       = 1'b0;
        ENA        = 5'd0;
        WR         = 1'b0;
        WSEL       = 3'd0;
        WDATA      = 15'd0;
        RSEL       = 3'd0;

        // Reset held 4 clocks, then 100 idle clocks.
        for (int i = 0; i < 4; i++) begin
            step();
            chk_zero("reset");
        end
        rst_ = 1'b1;
        cyc  = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            chk_zero("idle");
        end

        // Round-robin: X=2, Z=1, shaft=2 -> X, Z, S, X, S.
        ENA  = 5'b11111;
        RSEL = 3'd4;
        wr(3'd0, 15'd2);
        wr(3'd2, 15'd1);
        wr(3'd4, 15'd2);
        chk("rr_busy", {27'd0, BUSY}, 32'h15);
        slot(5'b00001, 1'b0, 5'b00000, 15'd2);
        slot(5'b00100, 1'b0, 5'b00100, 15'd2);
        slot(5'b10000, 1'b0, 5'b00000, 15'd1);
        slot(5'b00001, 1'b0, 5'b00001, 15'd1);
        slot(5'b10000, 1'b0, 5'b10000, 15'd0);
        slot(5'b00000, 1'b0, 5'b00000, 15'd0);
        chk("rr_idle_busy", {27'd0, BUSY}, 32'd0);

        // Single channel X=3.
        ENA  = 5'b00001;
        RSEL = 3'd0;
        wr(3'd0, 15'd3);
        chk("x_busy", {27'd0, BUSY}, 32'h01);
        chk("x_rdata", {17'd0, RDATA}, 32'd3);
        slot(5'b00001, 1'b0, 5'b00000, 15'd2);
        slot(5'b00001, 1'b0, 5'b00000, 15'd1);
        slot(5'b00001, 1'b0, 5'b00001, 15'd0);
        chk("x_end_busy", {27'd0, BUSY}, 32'd0);
        slot(5'b00000, 1'b0, 5'b00000, 15'd0);

        // Negative count on Y: -3, then -0.
        ENA  = 5'b00010;
        RSEL = 3'd1;
        wr(3'd1, 15'h7FFC);
        chk("y_rdata", {17'd0, RDATA}, 32'h7FFC);
        slot(5'b00010, 1'b1, 5'b00000, 15'h7FFD);
        slot(5'b00010, 1'b1, 5'b00000, 15'h7FFE);
        slot(5'b00010, 1'b1, 5'b00010, 15'h0000);
        wr(3'd1, 15'h7FFF);
        chk("y_m0_busy", {27'd0, BUSY}, 32'd0);
        chk("y_m0_rdata", {17'd0, RDATA}, 32'd0);
        slot(5'b00000, 1'b0, 5'b00000, 15'd0);

        // Abort: X=10, drop ENA[0] after 3 pulses, write while disabled.
        ENA  = 5'b00001;
        RSEL = 3'd0;
        wr(3'd0, 15'd10);
        slot(5'b00001, 1'b0, 5'b00000, 15'd9);
        slot(5'b00001, 1'b0, 5'b00000, 15'd8);
        slot(5'b00001, 1'b0, 5'b00000, 15'd7);
        ENA = 5'b00000;
        step();
        chk("abort_busy", {27'd0, BUSY}, 32'd0);
        chk("abort_rdata", {17'd0, RDATA}, 32'd0);
        wr(3'd0, 15'd5);
        chk("abort_wr_busy", {27'd0, BUSY}, 32'd0);
        chk("abort_wr_rdata", {17'd0, RDATA}, 32'd0);
        slot(5'b00000, 1'b0, 5'b00000, 15'd0);

        // Collision: X=1, write X=5 in the TICK clock (cyc 247 -> 248).
        ENA = 5'b00001;
        wr(3'd0, 15'd1);
        run_to(247);
        wr(3'd0, 15'd5);
        chk("col_drv", {27'd0, DRV}, 32'h01);
        chk("col_done", {27'd0, DONE}, 32'h01);
        chk("col_rdata", {17'd0, RDATA}, 32'd5);
        chk("col_busy", {27'd0, BUSY}, 32'h01);
        slot(5'b00001, 1'b0, 5'b00000, 15'd4);
        slot(5'b00001, 1'b0, 5'b00000, 15'd3);
        slot(5'b00001, 1'b0, 5'b00000, 15'd2);
        slot(5'b00001, 1'b0, 5'b00000, 15'd1);
        slot(5'b00001, 1'b0, 5'b00001, 15'd0);
        slot(5'b00000, 1'b0, 5'b00000, 15'd0);

        // Mid-drain reset asserted in a TICK clock.
        wr(3'd0, 15'd10);
        slot(5'b00001, 1'b0, 5'b00000, 15'd9);
        run_to(311);
        rst_ = 1'b0;
        step();
        chk_zero("midrst");
        rst_ = 1'b1;
        cyc  = 0;
        slot(5'b00000, 1'b0, 5'b00000, 15'd0);
        chk("post_rst_busy", {27'd0, BUSY}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_q, failures_q);
        $finish;
    end

endmodule
